// File: rtl/dec3t8_pulse.sv
// dec3t8_pulse -- sequenced 3-to-8 decoder.
//
// Takes an encoded line index over a valid/ready handshake. It drives the
// matching one-hot line on Y for PULSE_LEN cycles, then holds Y at zero for
// GAP_LEN cycles, and pulses done once per command. A null command (in_idle=1)
// runs the same timing but leaves Y at zero.
//
// Optional feature: define DEC3T8_QUEUE_EN to add a one-entry command queue.
// The queue allows back-to-back commands without an idle cycle between them.
//
// Parameters:
//   PULSE_LEN  cycles Y stays asserted per command (1..255)
//   GAP_LEN    forced Y=0 cycles after each pulse (0..255)
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-high
//   in_valid  command present
//   in_ready  block can accept a command this cycle (decoded from state)
//   A         encoded line index, A==k selects Y[k]
//   in_idle   null command: accepted and timed, no Y line driven
//   Y         registered one-hot (or all-zero) output
//   busy      not idle, or queue occupied (decoded from state)
//   done      registered 1-cycle pulse after each pulse period ends
module dec3t8_pulse #(
    parameter int unsigned PULSE_LEN = 1,
    parameter int unsigned GAP_LEN   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] A,
    input  logic       in_idle,
    output logic [7:0] Y,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_GAP
    } state_e;

    localparam logic [7:0] PULSE_CNT = 8'(PULSE_LEN - 1);
    localparam logic [7:0] GAP_CNT   = (GAP_LEN > 0) ? 8'(GAP_LEN - 1) : 8'd0;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] y_q, y_d;
    logic       done_q, done_d;
    logic       accept;

    function automatic logic [7:0] decode(input logic [2:0] idx, input logic nul);
        logic [7:0] onehot;
        onehot = 8'b1 << idx;
        return nul ? '0 : onehot;
    endfunction

`ifdef DEC3T8_QUEUE_EN
    logic       qv_q, qv_d;
    logic [2:0] qa_q, qa_d;
    logic       qidle_q, qidle_d;
    logic       leaving;

    // The current edge ends the period and would otherwise return to idle.
    assign leaving = ((state_q == ST_DRIVE) && (cnt_q == '0) && (GAP_LEN == 0)) ||
                     ((state_q == ST_GAP) && (cnt_q == '0));

    assign in_ready = !qv_q;
    assign busy     = (state_q != ST_IDLE) || qv_q;
`else
    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
`endif

    assign accept = in_valid & in_ready;
    assign Y      = y_q;
    assign done   = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        done_d  = 1'b0;
`ifdef DEC3T8_QUEUE_EN
        qv_d    = qv_q;
        qa_d    = qa_q;
        qidle_d = qidle_q;
`endif
        case (state_q)
            ST_IDLE: begin
                y_d = '0;
                if (accept) begin
                    state_d = ST_DRIVE;
                    y_d     = decode(A, in_idle);
                    cnt_d   = PULSE_CNT;
                end
            end
            ST_DRIVE: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == '0) begin
                    y_d    = '0;
                    done_d = 1'b1;
                    if (GAP_LEN > 0) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_CNT;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            ST_GAP: begin
                y_d   = '0;
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                y_d     = '0;
                cnt_d   = '0;
            end
        endcase
`ifdef DEC3T8_QUEUE_EN
        if (state_q != ST_IDLE) begin
            if (leaving && qv_q) begin
                state_d = ST_DRIVE;
                y_d     = decode(qa_q, qidle_q);
                cnt_d   = PULSE_CNT;
                qv_d    = 1'b0;
            end else if (leaving && accept) begin
                // Command arriving on the leaving edge with an empty queue is
                // written and popped in the same edge: start it directly.
                state_d = ST_DRIVE;
                y_d     = decode(A, in_idle);
                cnt_d   = PULSE_CNT;
            end else if (accept) begin
                qv_d    = 1'b1;
                qa_d    = A;
                qidle_d = in_idle;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
`ifdef DEC3T8_QUEUE_EN
            qv_q    <= 1'b0;
            qa_q    <= '0;
            qidle_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            done_q  <= done_d;
`ifdef DEC3T8_QUEUE_EN
            qv_q    <= qv_d;
            qa_q    <= qa_d;
            qidle_q <= qidle_d;
`endif
        end
    end

endmodule
